// File: rtl/clic_hart_target.sv
// clic_hart_target: hart-side CLIC receiver with level arbitration and a nesting stack.
// Ports: clk, rst_n; irq_valid_i/irq_ready_o handshake with id/level/shv/priv;
//        mie_i, mintthresh_i gating; cur_id/level/priv_o running context;
//        busy_o, depth_o, handler_done_o, ack_count_o status; vfetch_o.
// Optional macro CLIC_TARGET_SHV_EN: shv handshakes spend 2 cycles in VFETCH.
module clic_hart_target #(
    parameter int N_SOURCE       = 256,
    parameter int SRC_W          = $clog2(N_SOURCE),
    parameter int NEST_DEPTH     = 4,
    parameter int HANDLER_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            irq_valid_i,
    output logic                            irq_ready_o,
    input  logic [SRC_W-1:0]                irq_id_i,
    input  logic [7:0]                      irq_level_i,
    input  logic                            irq_shv_i,
    input  logic [1:0]                      irq_priv_i,
    input  logic                            mie_i,
    input  logic [7:0]                      mintthresh_i,
    output logic                            busy_o,
    output logic [SRC_W-1:0]                cur_id_o,
    output logic [7:0]                      cur_level_o,
    output logic [1:0]                      cur_priv_o,
    output logic [$clog2(NEST_DEPTH+1)-1:0] depth_o,
    output logic                            handler_done_o,
    output logic [15:0]                     ack_count_o,
    output logic                            vfetch_o
);

    localparam int DW = $clog2(NEST_DEPTH + 1);
    localparam int CW = $clog2(HANDLER_CYCLES + 1);
    localparam int PW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(NEST_DEPTH);
    localparam logic [CW-1:0] CNT_FULL  = CW'(HANDLER_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_VFETCH
    } state_e;

    state_e           state_q, state_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic [SRC_W-1:0] id_q, id_d;
    logic [7:0]       lvl_q, lvl_d;
    logic [1:0]       priv_q, priv_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic [15:0]      ack_q, ack_d;

    logic [SRC_W-1:0] stk_id_q   [NEST_DEPTH];
    logic [SRC_W-1:0] stk_id_d   [NEST_DEPTH];
    logic [7:0]       stk_lvl_q  [NEST_DEPTH];
    logic [7:0]       stk_lvl_d  [NEST_DEPTH];
    logic [1:0]       stk_priv_q [NEST_DEPTH];
    logic [1:0]       stk_priv_d [NEST_DEPTH];
    logic [CW-1:0]    stk_cnt_q  [NEST_DEPTH];
    logic [CW-1:0]    stk_cnt_d  [NEST_DEPTH];

    logic [7:0]    eff_thr;
    logic          ret;
    logic          acc;
    logic          hs;
    logic [PW-1:0] push_idx;
    logic [PW-1:0] pop_idx;

`ifdef CLIC_TARGET_SHV_EN
    logic vcnt_q, vcnt_d;
`else
    logic shv_unused;
    assign shv_unused = irq_shv_i;
`endif

    always_comb begin
        eff_thr = (lvl_q > mintthresh_i) ? lvl_q : mintthresh_i;
        // Last cycle of the running handler: its count is about to hit 0.
        ret = (state_q == S_RUN) && (cnt_q == CW'(1));
        acc = irq_valid_i && mie_i
              && (irq_level_i > eff_thr)
              && (depth_q < DEPTH_MAX)
              && !ret
              && (state_q != S_VFETCH);
        // Ready was granted a cycle earlier; a return landing on the
        // ready cycle must still win, so mask the handshake as well.
        hs = irq_valid_i && ready_q && !ret
             && (depth_q < DEPTH_MAX)
             && (state_q != S_VFETCH);
        push_idx = PW'(depth_q - DW'(1));
        pop_idx  = PW'(depth_q - DW'(2));
    end

    always_comb begin
        state_d    = state_q;
        ready_d    = acc && !ready_q;
        done_d     = 1'b0;
        id_d       = id_q;
        lvl_d      = lvl_q;
        priv_d     = priv_q;
        cnt_d      = cnt_q;
        depth_d    = depth_q;
        ack_d      = ack_q;
        stk_id_d   = stk_id_q;
        stk_lvl_d  = stk_lvl_q;
        stk_priv_d = stk_priv_q;
        stk_cnt_d  = stk_cnt_q;
`ifdef CLIC_TARGET_SHV_EN
        vcnt_d     = vcnt_q;
`endif
        if (hs) begin
            if (state_q == S_RUN) begin
                // The preempted handler has also run this cycle.
                stk_id_d[push_idx]   = id_q;
                stk_lvl_d[push_idx]  = lvl_q;
                stk_priv_d[push_idx] = priv_q;
                stk_cnt_d[push_idx]  = cnt_q - CW'(1);
            end
            id_d    = irq_id_i;
            lvl_d   = irq_level_i;
            priv_d  = irq_priv_i;
            cnt_d   = CNT_FULL;
            depth_d = depth_q + DW'(1);
            ack_d   = ack_q + 16'd1;
            state_d = S_RUN;
`ifdef CLIC_TARGET_SHV_EN
            if (irq_shv_i) begin
                state_d = S_VFETCH;
                vcnt_d  = 1'b0;
            end
`endif
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (ret) begin
                        done_d  = 1'b1;
                        depth_d = depth_q - DW'(1);
                        if (depth_q == DW'(1)) begin
                            state_d = S_IDLE;
                            id_d    = '0;
                            lvl_d   = 8'd0;
                            priv_d  = 2'b11;
                            cnt_d   = '0;
                        end else begin
                            id_d   = stk_id_q[pop_idx];
                            lvl_d  = stk_lvl_q[pop_idx];
                            priv_d = stk_priv_q[pop_idx];
                            cnt_d  = stk_cnt_q[pop_idx];
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
`ifdef CLIC_TARGET_SHV_EN
                S_VFETCH: begin
                    if (vcnt_q) begin
                        state_d = S_RUN;
                        cnt_d   = CNT_FULL;
                        vcnt_d  = 1'b0;
                    end else begin
                        vcnt_d = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            id_q       <= '0;
            lvl_q      <= 8'd0;
            priv_q     <= 2'b11;
            cnt_q      <= '0;
            depth_q    <= '0;
            ack_q      <= 16'd0;
            stk_id_q   <= '{default: '0};
            stk_lvl_q  <= '{default: '0};
            stk_priv_q <= '{default: '0};
            stk_cnt_q  <= '{default: '0};
`ifdef CLIC_TARGET_SHV_EN
            vcnt_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            id_q       <= id_d;
            lvl_q      <= lvl_d;
            priv_q     <= priv_d;
            cnt_q      <= cnt_d;
            depth_q    <= depth_d;
            ack_q      <= ack_d;
            stk_id_q   <= stk_id_d;
            stk_lvl_q  <= stk_lvl_d;
            stk_priv_q <= stk_priv_d;
            stk_cnt_q  <= stk_cnt_d;
`ifdef CLIC_TARGET_SHV_EN
            vcnt_q     <= vcnt_d;
`endif
        end
    end

    assign irq_ready_o    = ready_q;
    assign busy_o         = (state_q != S_IDLE);
    assign cur_id_o       = id_q;
    assign cur_level_o    = lvl_q;
    assign cur_priv_o     = priv_q;
    assign depth_o        = depth_q;
    assign handler_done_o = done_q;
    assign ack_count_o    = ack_q;
`ifdef CLIC_TARGET_SHV_EN
    assign vfetch_o       = (state_q == S_VFETCH);
`else
    assign vfetch_o       = 1'b0;
`endif

endmodule
